// File: rtl/hc595_rx_if.sv
// Pin-level bundle between a 74HC595-style serial driver and the receiver.
// The master drives the serial pins; the slave (receiver) returns the latched
// pattern and the decoded/status outputs.
interface hc595_rx_if;
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic       oe;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       disp_en;
  logic [3:0] hex_val;
  logic       hex_hit;
  logic [2:0] digit_idx;
  logic       sel_onehot;
  logic       frame_valid;
  logic       frame_err;

  modport master (
    output ds, shcp, stcp, oe,
    input  seg, sel, disp_en, hex_val, hex_hit, digit_idx, sel_onehot,
           frame_valid, frame_err
  );

  modport slave (
    input  ds, shcp, stcp, oe,
    output seg, sel, disp_en, hex_val, hex_hit, digit_idx, sel_onehot,
           frame_valid, frame_err
  );
endinterface

// File: rtl/hc595_rx.sv
// Receiver that snoops a 74HC595 serial bus (ds/shcp/stcp/oe) from the system
// clock domain, rebuilds the 14-bit {seg, sel} frame and decodes the glyph.
module hc595_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic       sys_clk,
  input logic       sys_rst_n,
  hc595_rx_if.slave bus
);

  localparam int unsigned Last     = SYNC_STAGES - 1;
  // Edge detection is trustworthy once the synchronizer and delay flop hold
  // real pin samples; until then a pin already high would look like an edge.
  localparam logic [2:0]  FillDone = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] ds_sync_q, shcp_sync_q, stcp_sync_q, oe_sync_q;
  logic [2:0]  fill_q;
  logic        primed;
  logic        shcp_dly_q, stcp_dly_q, ds_dly_q;
  logic        shcp_rise_d, stcp_rise_d;
  logic        shcp_rise_q, stcp_rise_q;
  logic [13:0] shreg_q;
  logic [3:0]  count_q;
  logic [7:0]  seg_q;
  logic [5:0]  sel_q;
  logic        frame_valid_q, frame_err_q;
  logic        disp_en_q;
  logic [3:0]  hex_val_q, hex_val_d;
  logic        hex_hit_q, hex_hit_d;
  logic [2:0]  digit_idx_q, digit_idx_d;
  logic        sel_onehot_q, sel_onehot_d;

  // Input synchronizers; ds and shcp share the same depth so data lines up.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ds_sync_q   <= '0;
      shcp_sync_q <= '0;
      stcp_sync_q <= '0;
      oe_sync_q   <= '0;
    end else begin
      ds_sync_q   <= {ds_sync_q[SYNC_STAGES-2:0], bus.ds};
      shcp_sync_q <= {shcp_sync_q[SYNC_STAGES-2:0], bus.shcp};
      stcp_sync_q <= {stcp_sync_q[SYNC_STAGES-2:0], bus.stcp};
      oe_sync_q   <= {oe_sync_q[SYNC_STAGES-2:0], bus.oe};
    end
  end

  // Post-reset fill counter that arms edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fill_q <= '0;
    end else if (fill_q != FillDone) begin
      fill_q <= fill_q + 3'd1;
    end
  end

  always_comb begin
    primed      = (fill_q == FillDone);
    shcp_rise_d = primed & shcp_sync_q[Last] & ~shcp_dly_q;
    stcp_rise_d = primed & stcp_sync_q[Last] & ~stcp_dly_q;
  end

  // Edge delay flops and registered edge strobes; ds_dly_q stays aligned with them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shcp_dly_q  <= 1'b0;
      stcp_dly_q  <= 1'b0;
      ds_dly_q    <= 1'b0;
      shcp_rise_q <= 1'b0;
      stcp_rise_q <= 1'b0;
    end else begin
      shcp_dly_q  <= shcp_sync_q[Last];
      stcp_dly_q  <= stcp_sync_q[Last];
      ds_dly_q    <= ds_sync_q[Last];
      shcp_rise_q <= shcp_rise_d;
      stcp_rise_q <= stcp_rise_d;
    end
  end

  // Shift, count and storage; storage sees the pre-shift word and pre-increment count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shreg_q       <= '0;
      count_q       <= '0;
      seg_q         <= 8'hFF;
      sel_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (shcp_rise_q) begin
        shreg_q <= {shreg_q[12:0], ds_dly_q};
      end
      if (stcp_rise_q) begin
        // A shift in the same cycle is the first bit of the next frame.
        count_q <= shcp_rise_q ? 4'd1 : 4'd0;
        if (count_q == 4'd14) begin
          seg_q         <= shreg_q[13:6];
          sel_q         <= shreg_q[5:0];
          frame_valid_q <= 1'b1;
        end else begin
          frame_err_q <= 1'b1;
        end
      end else if (shcp_rise_q && count_q != 4'd15) begin
        count_q <= count_q + 4'd1;
      end
    end
  end

  // Glyph and digit-select decode of the currently latched pattern.
  always_comb begin
    hex_val_d = 4'h0;
    hex_hit_d = 1'b1;
    case (seg_q[6:0])
      7'h40:   hex_val_d = 4'h0;
      7'h79:   hex_val_d = 4'h1;
      7'h24:   hex_val_d = 4'h2;
      7'h30:   hex_val_d = 4'h3;
      7'h19:   hex_val_d = 4'h4;
      7'h12:   hex_val_d = 4'h5;
      7'h02:   hex_val_d = 4'h6;
      7'h78:   hex_val_d = 4'h7;
      7'h00:   hex_val_d = 4'h8;
      7'h10:   hex_val_d = 4'h9;
      7'h08:   hex_val_d = 4'hA;
      7'h03:   hex_val_d = 4'hB;
      7'h46:   hex_val_d = 4'hC;
      7'h21:   hex_val_d = 4'hD;
      7'h06:   hex_val_d = 4'hE;
      7'h0E:   hex_val_d = 4'hF;
      default: hex_hit_d = 1'b0;
    endcase

    sel_onehot_d = ($countones(sel_q) == 1);
    digit_idx_d  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (sel_q[i]) digit_idx_d = 3'(i);
    end
    if (!sel_onehot_d) digit_idx_d = 3'd0;
  end

  // Registered decode outputs and display enable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hex_val_q    <= '0;
      hex_hit_q    <= 1'b0;
      digit_idx_q  <= '0;
      sel_onehot_q <= 1'b0;
      disp_en_q    <= 1'b0;
    end else begin
      hex_val_q    <= hex_val_d;
      hex_hit_q    <= hex_hit_d;
      digit_idx_q  <= digit_idx_d;
      sel_onehot_q <= sel_onehot_d;
      disp_en_q    <= ~oe_sync_q[Last];
    end
  end

  assign bus.seg         = seg_q;
  assign bus.sel         = sel_q;
  assign bus.disp_en     = disp_en_q;
  assign bus.hex_val     = hex_val_q;
  assign bus.hex_hit     = hex_hit_q;
  assign bus.digit_idx   = digit_idx_q;
  assign bus.sel_onehot  = sel_onehot_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: doc/hc595_rx.md
HC595_RX -- requirements
Module: hc595_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-002 sys_clk  input  1  single system clock, 50 MHz; all logic on its rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ds  input  1  serial data from a 74HC595 driver, asynchronous to sys_clk.
REQ-005 shcp  input  1  shift clock; one bit is captured per rising edge.
REQ-006 stcp  input  1  storage clock; a rising edge transfers the shift register to the outputs.
REQ-007 oe  input  1  output enable, active-low.
REQ-008 seg  output  8  latched segment pattern, active-low (bit7 = dp, bit0 = a).
REQ-009 sel  output  6  latched digit select, one-hot active-high.
REQ-010 disp_en  output  1  registered ~oe after synchronization.
REQ-011 hex_val  output  4  hex digit decoded from seg.
REQ-012 hex_hit  output  1  1 when seg[6:0] matches one of the 16 hex glyphs.
REQ-013 digit_idx  output  3  index of the set sel bit; valid only when sel_onehot = 1.
REQ-014 sel_onehot  output  1  1 when exactly one sel bit is set.
REQ-015 frame_valid  output  1  one-cycle pulse when a storage edge follows exactly 14 shifted bits.
REQ-016 frame_err  output  1  one-cycle pulse when a storage edge follows any bit count other than 14.

Function
REQ-017 ds, shcp, stcp and oe SHALL each pass through a SYNC_STAGES-flop synchronizer; rising edges SHALL be detected from the last stage and one extra delay flop.
REQ-018 On a detected shcp rising edge, the 14-bit shift register SHALL shift left and load synchronized ds into bit 0; ds and shcp SHALL share the same synchronizer delay.
REQ-019 The frame word SHALL be {seg[7:0], sel[5:0]}: the first bit shifted becomes seg[7], the last becomes sel[0].
REQ-020 The bit counter SHALL be 4 bits wide, increment on each shift, and saturate at 15.
REQ-021 On a detected stcp rising edge with count = 14, the block SHALL load seg and sel from the shift register, pulse frame_valid, and clear the count to 0.
REQ-022 On a detected stcp rising edge with count != 14 (including 0), the block SHALL pulse frame_err, hold seg and sel unchanged, and clear the count.
REQ-023 The shift register SHALL NOT be cleared by stcp, so that 74HC595 hold behaviour is kept.
REQ-024 If shcp and stcp edges are detected in the same cycle, the storage SHALL use the pre-shift register and pre-increment count, the shift SHALL still occur, and the count SHALL become 1.
REQ-025 Latency: with SYNC_STAGES = 2, a pin edge at sys_clk edge 0 SHALL update seg, sel and frame_valid/frame_err at edge 4.
REQ-026 hex_val, hex_hit, digit_idx and sel_onehot SHALL be registered from seg and sel, one cycle after the seg/sel update.
REQ-027 The hex table (active-low, dp ignored) SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-028 On no hex match, hex_hit SHALL be 0 and hex_val SHALL be 0.
REQ-029 When sel_onehot = 0, digit_idx SHALL be 0.
REQ-030 disp_en SHALL follow oe with the synchronizer delay plus 1 cycle; seg and sel SHALL NOT be gated by oe.
REQ-031 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-032 While sys_rst_n = 0: synchronizers, edge flops, shift register and count SHALL be 0.
REQ-033 While sys_rst_n = 0: seg SHALL be 8'hFF, sel 6'h00, disp_en 0, hex_val 0, hex_hit 0, digit_idx 0, sel_onehot 0, frame_valid 0, frame_err 0.
REQ-034 A reset during a frame SHALL discard all bits already shifted; the first storage edge after reset with count != 14 SHALL produce frame_err.
REQ-035 The synchronizer reset value of 0 SHALL NOT create a false edge if shcp or stcp is already high when reset releases.

Verification
REQ-036 Send 14 bits for word {8'hC0, 6'b111111} at 1 MHz shcp, then an stcp pulse -> frame_valid one pulse, seg = C0, sel = 3F, hex_val = 0, hex_hit = 1, sel_onehot = 0, digit_idx = 0.
REQ-037 Send {8'h99, 6'b000100} then stcp -> seg = 99, hex_val = 4, sel_onehot = 1, digit_idx = 2.
REQ-038 Send 13 bits then stcp -> frame_err pulse, seg/sel unchanged from the previous frame; next 14-bit frame -> frame_valid.
REQ-039 Send 16 bits then stcp -> frame_err, count saturated at 15 beforehand; seg/sel unchanged.
REQ-040 Raise shcp and stcp on the same sys_clk edge after 14 bits -> frame_valid, outputs hold the pre-shift word, and the following frame needs 13 more bits.
REQ-041 Pull sys_rst_n low after 7 bits, release, then send 14 bits plus stcp -> all outputs at reset values during reset, then frame_valid with the new word; toggle oe -> disp_en follows with 3-cycle delay.
